fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 144 ++++++++++++++
 tb/tb_fetch_unit.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, memory request handshake, stall hold buffer, HLT and redirect.
// Optional macro FETCH_PERF_CNT_EN adds saturating wait_cycles and flush_count outputs.
`timescale 1ns/1ps
module fetch_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [15:0] branch_target,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic [15:0] imem_data,
  input  logic        imem_valid,
  output logic [15:0] instruction,
  output logic [15:0] PC_plus_two,
  output logic        if_write,
  output logic        if_flush,
  output logic        halted,
  output logic [15:0] pc_out
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [15:0] wait_cycles,
  output logic [15:0] flush_count
`endif
);

  typedef enum logic [1:0] {S_FETCH, S_HOLD, S_HALT} state_t;

  localparam logic [15:0] NOP = 16'h1000;

  state_t      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] hold_q, hold_d;
  logic [15:0] pc_inc;

  function automatic logic is_hlt(input logic [15:0] word);
    return word[15:12] == 4'hF;
  endfunction

  assign pc_inc    = pc_q + 16'd2;
  assign imem_addr = pc_q;
  assign pc_out    = pc_q;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    hold_d      = hold_q;
    imem_req    = 1'b0;
    if_write    = 1'b0;
    if_flush    = 1'b0;
    halted      = 1'b0;
    instruction = NOP;
    PC_plus_two = pc_inc;

    if (branch_taken) begin
      // Redirect beats stall and discards whatever memory returns this cycle.
      if_write = 1'b1;
      if_flush = 1'b1;
      pc_d     = branch_target;
      state_d  = S_FETCH;
    end else begin
      case (state_q)
        S_FETCH: begin
          imem_req = 1'b1;
          if (imem_valid && !stall) begin
            if_write    = 1'b1;
            instruction = imem_data;
            if (is_hlt(imem_data)) state_d = S_HALT;
            else                   pc_d    = pc_inc;
          end else if (imem_valid) begin
            hold_d  = imem_data;
            state_d = S_HOLD;
          end else begin
            if_write = !stall;
            if_flush = !stall;
          end
        end
        S_HOLD: begin
          instruction = hold_q;
          if (!stall) begin
            if_write = 1'b1;
            if (is_hlt(hold_q)) begin
              state_d = S_HALT;
            end else begin
              pc_d    = pc_inc;
              state_d = S_FETCH;
            end
          end
        end
        S_HALT: begin
          halted   = 1'b1;
          if_write = !stall;
          if_flush = 1'b1;
        end
        default: state_d = S_FETCH;
      endcase
    end

    if (!rst) begin
      imem_req    = 1'b0;
      if_write    = 1'b0;
      if_flush    = 1'b0;
      halted      = 1'b0;
      instruction = NOP;
      PC_plus_two = 16'h0002;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_FETCH;
      pc_q    <= 16'h0000;
      hold_q  <= 16'h0000;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      hold_q  <= hold_d;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [15:0] wait_q, flush_q;
  logic        wait_hit;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign wait_hit    = (state_q == S_FETCH) && !branch_taken && !imem_valid;
  assign wait_cycles = wait_q;
  assign flush_count = flush_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      wait_q  <= 16'h0000;
      flush_q <= 16'h0000;
    end else begin
      if (wait_hit)     wait_q  <= sat_inc(wait_q);
      if (branch_taken) flush_q <= sat_inc(flush_q);
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: expected deliveries are queued with the stimulus
// and matched by a monitor whenever a non-flushed word is written to IF/ID.
`timescale 1ns/1ps
module tb_fetch_unit;

  logic        clk, rst, stall, branch_taken, imem_valid;
  logic [15:0] branch_target, imem_data;
  logic        imem_req, if_write, if_flush, halted;
  logic [15:0] imem_addr, instruction, PC_plus_two, pc_out;
`ifdef FETCH_PERF_CNT_EN
  logic [15:0] wait_cycles, flush_count;
  logic [15:0] w0, f0;
`endif

  int checks = 0;
  int errors = 0;
  logic [31:0] sb_q[$];
  logic [31:0] mon_exp;

  fetch_unit dut (
    .clk(clk), .rst(rst), .stall(stall), .branch_taken(branch_taken),
    .branch_target(branch_target), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_data(imem_data), .imem_valid(imem_valid), .instruction(instruction),
    .PC_plus_two(PC_plus_two), .if_write(if_write), .if_flush(if_flush),
    .halted(halted), .pc_out(pc_out)
`ifdef FETCH_PERF_CNT_EN
    , .wait_cycles(wait_cycles), .flush_count(flush_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Monitor: inputs change at the falling edge, outputs are sampled 2ns later.
  always begin
    @(negedge clk);
    #2;
    if (rst) begin
      if (if_flush) begin
        checks++;
        if (instruction !== 16'h1000) begin errors++; $display("FAIL flush_nop: instruction=%h required 1000", instruction); end
      end
      if (if_write && !if_flush) begin
        checks++;
        if (sb_q.size() == 0) begin
          errors++; $display("FAIL delivery: unexpected word %h ppt=%h, none required", instruction, PC_plus_two);
        end else begin
          mon_exp = sb_q.pop_front();
          if ({instruction, PC_plus_two} !== mon_exp) begin
            errors++; $display("FAIL delivery: got %h/%h required %h/%h", instruction, PC_plus_two, mon_exp[31:16], mon_exp[15:0]);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    imem_valid = 1'b1; imem_data = 16'hF000;
    #1;
    checks++; if (imem_req !== 1'b0)        begin errors++; $display("FAIL rst_req: %b required 0", imem_req); end
    checks++; if (if_write !== 1'b0)        begin errors++; $display("FAIL rst_ifw: %b required 0", if_write); end
    checks++; if (if_flush !== 1'b0)        begin errors++; $display("FAIL rst_flush: %b required 0", if_flush); end
    checks++; if (halted !== 1'b0)          begin errors++; $display("FAIL rst_halted: %b required 0", halted); end
    checks++; if (instruction !== 16'h1000) begin errors++; $display("FAIL rst_instr: %h required 1000", instruction); end
    checks++; if (PC_plus_two !== 16'h0002) begin errors++; $display("FAIL rst_ppt: %h required 0002", PC_plus_two); end
    checks++; if (pc_out !== 16'h0000)      begin errors++; $display("FAIL rst_pc: %h required 0000", pc_out); end
`ifdef FETCH_PERF_CNT_EN
    checks++; if (wait_cycles !== 16'h0000 || flush_count !== 16'h0000) begin errors++; $display("FAIL rst_cnt: %h/%h required 0/0", wait_cycles, flush_count); end
`endif
    imem_valid = 1'b0;
  endtask

  task automatic test_zero_wait();
    rst = 1'b1; imem_valid = 1'b1; imem_data = 16'hA123; sb_q.push_back({16'hA123, 16'h0002});
    #1;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 16'h0000) begin errors++; $display("FAIL zw_first: req=%b addr=%h required 1/0000", imem_req, imem_addr); end
    tick();
    imem_data = 16'hB456; sb_q.push_back({16'hB456, 16'h0004});
    #1;
    checks++; if (imem_addr !== 16'h0002) begin errors++; $display("FAIL zw_addr: %h required 0002", imem_addr); end
    tick();
    imem_valid = 1'b0; stall = 1'b1;
    #1;
    checks++; if (pc_out !== 16'h0004 || if_write !== 1'b0) begin errors++; $display("FAIL zw_idle: pc=%h ifw=%b required 0004/0", pc_out, if_write); end
  endtask

  task automatic test_latency();
    stall = 1'b0; imem_valid = 1'b0;
`ifdef FETCH_PERF_CNT_EN
    w0 = wait_cycles;
`endif
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (if_flush !== 1'b1 || if_write !== 1'b1 || imem_addr !== 16'h0004) begin
        errors++; $display("FAIL lat_bubble%0d: flush=%b ifw=%b addr=%h required 1/1/0004", i, if_flush, if_write, imem_addr); end
      tick();
    end
    imem_valid = 1'b1; imem_data = 16'h1111; sb_q.push_back({16'h1111, 16'h0006});
    #1;
`ifdef FETCH_PERF_CNT_EN
    checks++; if (wait_cycles !== w0 + 16'd3) begin errors++; $display("FAIL lat_waitcnt: %0d required %0d", wait_cycles, w0 + 16'd3); end
`endif
    tick();
  endtask

  task automatic test_stall();
    stall = 1'b1; imem_valid = 1'b1; imem_data = 16'h2345;
    #1;
    checks++; if (if_write !== 1'b0 || imem_req !== 1'b1) begin errors++; $display("FAIL st_cap: ifw=%b req=%b required 0/1", if_write, imem_req); end
    tick();
    imem_valid = 1'b0;
    #1;
    checks++; if (if_write !== 1'b0 || imem_req !== 1'b0 || pc_out !== 16'h0006) begin
      errors++; $display("FAIL st_hold: ifw=%b req=%b pc=%h required 0/0/0006", if_write, imem_req, pc_out); end
    tick();
    stall = 1'b0; sb_q.push_back({16'h2345, 16'h0008});
    #1;
    checks++; if (if_write !== 1'b1 || instruction !== 16'h2345) begin errors++; $display("FAIL st_release: ifw=%b instr=%h required 1/2345", if_write, instruction); end
    tick();
    stall = 1'b1;
    #1;
    checks++; if (pc_out !== 16'h0008 || imem_req !== 1'b1) begin errors++; $display("FAIL st_adv: pc=%h req=%b required 0008/1", pc_out, imem_req); end
  endtask

  task automatic test_branch();
    stall = 1'b0; imem_valid = 1'b0;
    tick();
`ifdef FETCH_PERF_CNT_EN
    f0 = flush_count;
`endif
    branch_taken = 1'b1; branch_target = 16'h0040; stall = 1'b1; imem_valid = 1'b1; imem_data = 16'h7777;
    #1;
    checks++; if (if_write !== 1'b1 || if_flush !== 1'b1 || instruction !== 16'h1000 || imem_req !== 1'b0) begin
      errors++; $display("FAIL br_cycle: ifw=%b flush=%b instr=%h req=%b required 1/1/1000/0", if_write, if_flush, instruction, imem_req); end
    tick();
    branch_taken = 1'b0; imem_valid = 1'b0;
    #1;
    checks++; if (imem_addr !== 16'h0040 || imem_req !== 1'b1) begin errors++; $display("FAIL br_target: addr=%h req=%b required 0040/1", imem_addr, imem_req); end
`ifdef FETCH_PERF_CNT_EN
    checks++; if (flush_count !== f0 + 16'd1) begin errors++; $display("FAIL br_flushcnt: %0d required %0d", flush_count, f0 + 16'd1); end
`endif
  endtask

  task automatic test_halt();
    branch_taken = 1'b1; branch_target = 16'h0010; stall = 1'b0; imem_valid = 1'b0;
    tick();
    branch_taken = 1'b0; imem_valid = 1'b1; imem_data = 16'hF000; sb_q.push_back({16'hF000, 16'h0012});
    tick();
    imem_valid = 1'b0;
    #1;
    checks++; if (halted !== 1'b1 || pc_out !== 16'h0010 || imem_req !== 1'b0 || if_flush !== 1'b1 || if_write !== 1'b1) begin
      errors++; $display("FAIL hlt_state: halted=%b pc=%h req=%b flush=%b ifw=%b required 1/0010/0/1/1", halted, pc_out, imem_req, if_flush, if_write); end
    tick();
    stall = 1'b1;
    #1;
    checks++; if (if_write !== 1'b0 || halted !== 1'b1 || pc_out !== 16'h0010) begin
      errors++; $display("FAIL hlt_stall: ifw=%b halted=%b pc=%h required 0/1/0010", if_write, halted, pc_out); end
    tick();
    branch_taken = 1'b1; branch_target = 16'h0020; stall = 1'b0;
    tick();
    branch_taken = 1'b0; stall = 1'b1;
    #1;
    checks++; if (halted !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 16'h0020) begin
      errors++; $display("FAIL hlt_resume: halted=%b req=%b addr=%h required 0/1/0020", halted, imem_req, imem_addr); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] pc_m;
    pc_m = 16'h0020; stall = 1'b0; imem_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      imem_data = 16'h0100 + 16'(i * 7);
      sb_q.push_back({imem_data, pc_m + 16'd2});
      pc_m = pc_m + 16'd2;
      tick();
    end
    imem_valid = 1'b0; stall = 1'b1;
    #1;
    checks++; if (pc_out !== pc_m) begin errors++; $display("FAIL b2b_pc: %h required %h", pc_out, pc_m); end
  endtask

  task automatic test_wrap_and_reset();
    branch_taken = 1'b1; branch_target = 16'h0033;
    tick();
    branch_taken = 1'b0;
    #1;
    checks++; if (pc_out !== 16'h0033) begin errors++; $display("FAIL odd_target: %h required 0033", pc_out); end
    branch_taken = 1'b1; branch_target = 16'hFFFE;
    tick();
    branch_taken = 1'b0; stall = 1'b0; imem_valid = 1'b1; imem_data = 16'h1234; sb_q.push_back({16'h1234, 16'h0000});
    #1;
    checks++; if (imem_addr !== 16'hFFFE) begin errors++; $display("FAIL wrap_addr: %h required FFFE", imem_addr); end
    tick();
    imem_valid = 1'b0;
    #1;
    checks++; if (pc_out !== 16'h0000 || imem_req !== 1'b1) begin errors++; $display("FAIL wrap_pc: pc=%h req=%b required 0000/1", pc_out, imem_req); end
    tick();
    rst = 1'b0;
    #1;
    checks++; if (imem_req !== 1'b0 || if_flush !== 1'b0 || if_write !== 1'b0 || instruction !== 16'h1000 || PC_plus_two !== 16'h0002) begin
      errors++; $display("FAIL midreq_rst: req=%b flush=%b ifw=%b instr=%h ppt=%h required 0/0/0/1000/0002", imem_req, if_flush, if_write, instruction, PC_plus_two); end
    tick();
    rst = 1'b1;
    #1;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 16'h0000) begin errors++; $display("FAIL midreq_release: req=%b addr=%h required 1/0000", imem_req, imem_addr); end
    stall = 1'b1; imem_valid = 1'b1; imem_data = 16'h5555;
    tick();
    rst = 1'b0; imem_valid = 1'b0;
    tick();
    rst = 1'b1; stall = 1'b0;
    #1;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 16'h0000 || if_flush !== 1'b1) begin
      errors++; $display("FAIL hold_rst: req=%b addr=%h flush=%b required 1/0000/1", imem_req, imem_addr, if_flush); end
    tick();
    stall = 1'b1;
    tick();
  endtask

  initial begin
    rst = 1'b0; stall = 1'b0; branch_taken = 1'b0; branch_target = 16'h0000;
    imem_valid = 1'b0; imem_data = 16'h0000;
    test_reset();
    test_zero_wait();
    test_latency();
    test_stall();
    test_branch();
    test_halt();
    test_back_to_back();
    test_wrap_and_reset();
    checks++;
    if (sb_q.size() != 0) begin errors++; $display("FAIL sb_drain: %0d words never delivered, required 0", sb_q.size()); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
